// File: rtl/median_filter_ctrl.sv
// Frame sequencer for a FIFO-buffered median filter: load a frame into FIFO1, stream it
// through the median stage into FIFO2, then unload FIFO2. A watchdog aborts a stalled drain.
module median_filter_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int ROW        = 256,
    parameter int COL        = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic                med_valid,
    output logic                in_ready,
    output logic                fifo1_en,
    output logic                fifo1_push_pop,
    output logic                fifo2_en,
    output logic                fifo2_push_pop,
    output logic                med_valid_in,
    output logic                out_valid,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_WIDTH:0] pix_cnt
);

    localparam int                CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(ROW * COL - 1);
    localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILTER, S_DRAIN, S_UNLOAD, S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_load_cnt;
    logic [CNT_W-1:0]   r_pop_cnt;
    logic [CNT_W-1:0]   r_res_cnt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic               r_med_valid_in;
    logic               r_out_valid;
    logic               r_err;

    logic w_push1, w_pop1, w_push2, w_pop2, w_last_res;

    // NOTE: push strobes follow in_valid/med_valid in the same cycle so the FIFO captures the
    // word it is being offered; every other output is decoded from or held in a flop.
    assign w_push1    = (r_state == S_LOAD) && in_valid;
    assign w_pop1     = (r_state == S_FILTER);
    assign w_push2    = ((r_state == S_FILTER) || (r_state == S_DRAIN)) && med_valid;
    assign w_pop2     = (r_state == S_UNLOAD);
    assign w_last_res = w_push2 && (r_res_cnt == LAST_PIX);

    assign in_ready       = (r_state == S_LOAD);
    assign fifo1_en       = w_push1 || w_pop1;
    assign fifo1_push_pop = w_push1;
    assign fifo2_en       = w_push2 || w_pop2;
    assign fifo2_push_pop = w_push2;
    assign med_valid_in   = r_med_valid_in;
    assign out_valid      = r_out_valid;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign err            = r_err;

    always_comb begin
        pix_cnt = '0;
        case (r_state)
            S_LOAD:   pix_cnt = r_load_cnt;
            S_FILTER: pix_cnt = r_pop_cnt;
            S_DRAIN:  pix_cnt = r_res_cnt;
            S_UNLOAD: pix_cnt = r_out_cnt;
            default:  pix_cnt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_load_cnt     <= '0;
            r_pop_cnt      <= '0;
            r_res_cnt      <= '0;
            r_out_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_med_valid_in <= 1'b0;
            r_out_valid    <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            // FIFO read latency is one cycle, so the data qualifiers trail the pop strobes.
            r_med_valid_in <= w_pop1;
            r_out_valid    <= w_pop2;
            if (w_push1) r_load_cnt <= r_load_cnt + 1'b1;
            if (w_pop1)  r_pop_cnt  <= r_pop_cnt + 1'b1;
            if (w_push2) r_res_cnt  <= r_res_cnt + 1'b1;
            if (w_pop2)  r_out_cnt  <= r_out_cnt + 1'b1;
            if (r_state == S_DRAIN)
                r_idle_cnt <= med_valid ? '0 : r_idle_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_load_cnt <= '0;
                        r_pop_cnt  <= '0;
                        r_res_cnt  <= '0;
                        r_out_cnt  <= '0;
                        r_idle_cnt <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_push1 && (r_load_cnt == LAST_PIX)) r_state <= S_FILTER;
                end
                S_FILTER: begin
                    if (w_last_res)                    r_state <= S_UNLOAD;
                    else if (r_pop_cnt == LAST_PIX)    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_last_res) begin
                        r_state <= S_UNLOAD;
                    end else if (!med_valid && (r_idle_cnt == LAST_IDLE)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_UNLOAD: begin
                    if (r_out_cnt == LAST_PIX) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Directed bench for median_filter_ctrl (4x4 frame, drain timeout 8, median stage latency 3).
module tb_median_filter_ctrl;

    localparam int NPIX = 16;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, med_valid;
    logic        in_ready, fifo1_en, fifo1_push_pop, fifo2_en, fifo2_push_pop;
    logic        med_valid_in, out_valid, busy, done, err;
    logic [16:0] pix_cnt;

    int passed = 0;
    int total  = 0;

    // Median stage model: result appears 3 cycles after each FIFO1 pop, capped at res_limit.
    logic [1:0] sr;
    int         res_given;
    int         res_limit;
    logic       med_force;

    // Monitor state, cleared on request.
    logic mon_clr;
    int   cyc, push1, pop1, mvi, push2, pop2, ov, done_cnt, viol;
    int   pop1_first, pop1_last, pop2_first, pop2_last, push2_last, err_cyc;
    logic prev_pop1, prev_pop2, prev_err;

    always #5 clk = ~clk;

    median_filter_ctrl #(.ADDR_WIDTH(16), .ROW(4), .COL(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .med_valid(med_valid),
        .in_ready(in_ready), .fifo1_en(fifo1_en), .fifo1_push_pop(fifo1_push_pop),
        .fifo2_en(fifo2_en), .fifo2_push_pop(fifo2_push_pop), .med_valid_in(med_valid_in),
        .out_valid(out_valid), .busy(busy), .done(done), .err(err), .pix_cnt(pix_cnt)
    );

    assign med_valid = med_force | (sr[1] & (res_given < res_limit));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr        <= '0;
            res_given <= 0;
        end else begin
            sr <= {sr[0], med_valid_in};
            if (start && !busy)                  res_given <= 0;
            else if (fifo2_en && fifo2_push_pop) res_given <= res_given + 1;
        end
    end

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_pop1 <= fifo1_en & ~fifo1_push_pop;
        prev_pop2 <= fifo2_en & ~fifo2_push_pop;
        prev_err  <= err;
        if (mon_clr) begin
            push1 <= 0; pop1 <= 0; mvi <= 0; push2 <= 0; pop2 <= 0; ov <= 0;
            done_cnt <= 0; viol <= 0; pop1_first <= -1; pop1_last <= -1;
            pop2_first <= -1; pop2_last <= -1; push2_last <= -1; err_cyc <= -1;
        end else begin
            if (fifo1_en && fifo1_push_pop) begin
                push1 <= push1 + 1;
                if (!in_valid) viol <= viol + 1;
            end
            if (fifo1_en && !fifo1_push_pop) begin
                pop1 <= pop1 + 1;
                if (pop1 == 0) pop1_first <= cyc;
                pop1_last <= cyc;
            end
            if (fifo2_en && fifo2_push_pop) begin
                push2 <= push2 + 1;
                push2_last <= cyc;
            end
            if (fifo2_en && !fifo2_push_pop) begin
                pop2 <= pop2 + 1;
                if (pop2 == 0) pop2_first <= cyc;
                pop2_last <= cyc;
                if (push2 != NPIX) viol <= viol + 1;
            end
            if (med_valid_in) mvi <= mvi + 1;
            if (out_valid)    ov  <= ov + 1;
            if (done)         done_cnt <= done_cnt + 1;
            if (!reset && ((med_valid_in !== prev_pop1) || (out_valid !== prev_pop2)))
                viol <= viol + 1;
            if (err && !prev_err) err_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed16();
        in_valid = 1'b1;
        repeat (NPIX) tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (3) tick();
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({in_ready, fifo1_en, fifo2_en, med_valid_in, out_valid, busy, done, err, pix_cnt} !== '0)
            $display("FAIL reset_hold: outputs not all zero");
        else passed++;
        tick();
        reset = 1'b0;
        clear_mon();
        do_start();
        in_valid = 1'b1;
        repeat (3) tick();
        total++;
        if ({busy, fifo1_en, pix_cnt} !== {2'b11, 17'd3})
            $display("FAIL pre_reset: got busy/en/cnt %b/%b/%0d expected 1/1/3", busy, fifo1_en, pix_cnt);
        else passed++;
        #3 reset = 1'b1;
        #1;
        total++;
        if ({in_ready, fifo1_en, fifo1_push_pop, fifo2_en, fifo2_push_pop, med_valid_in,
             out_valid, busy, done, err, pix_cnt} !== '0)
            $display("FAIL async_reset: outputs %b cnt %0d expected all zero",
                     {in_ready, fifo1_en, fifo2_en, busy, done, err}, pix_cnt);
        else passed++;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        if (busy !== 1'b0) begin total++; $display("FAIL reset_idle: busy %b expected 0", busy); end
        else begin total++; passed++; end
    endtask

    task automatic test_normal_frame();
        bit seen;
        clear_mon();
        res_limit = NPIX;
        do_start();
        chk("load_in_ready", in_ready, 1);
        chk("load_cnt0", pix_cnt, 0);
        feed16();
        chk("filter_in_ready", in_ready, 0);
        chk("filter_pop", {fifo1_en, fifo1_push_pop}, 2'b10);
        wait_done(seen);
        chk("normal_done_seen", seen, 1);
        chk("normal_push1", push1, NPIX);
        chk("normal_pop1", pop1, NPIX);
        chk("normal_pop1_span", pop1_last - pop1_first, NPIX - 1);
        chk("normal_mvi", mvi, NPIX);
        chk("normal_push2", push2, NPIX);
        chk("normal_pop2", pop2, NPIX);
        chk("normal_pop2_span", pop2_last - pop2_first, NPIX - 1);
        chk("normal_unload_start", pop2_first, push2_last + 1);
        chk("normal_out_valid", ov, NPIX);
        chk("normal_done_cnt", done_cnt, 1);
        chk("normal_viol", viol, 0);
        chk("normal_idle", {busy, err}, 0);
    endtask

    task automatic test_gapped_input();
        bit seen;
        clear_mon();
        res_limit = NPIX;
        do_start();
        for (int i = 0; i < 31; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            if (i == 28) begin
                chk("gap_still_load", in_ready, 1);
                chk("gap_cnt15", pix_cnt, 15);
            end
        end
        in_valid = 1'b0;
        chk("gap_filter_entered", {in_ready, fifo1_en, fifo1_push_pop}, 3'b010);
        chk("gap_push1", push1, NPIX);
        wait_done(seen);
        chk("gap_done_seen", seen, 1);
        chk("gap_done_cnt", done_cnt, 1);
        chk("gap_viol", viol, 0);
    endtask

    task automatic test_timeout();
        bit seen;
        clear_mon();
        res_limit = 10;
        do_start();
        feed16();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        chk("to_err_seen", seen, 1);
        chk("to_err_held", err, 1);
        chk("to_idle", busy, 0);
        chk("to_err_latency", err_cyc - pop1_last, 9);
        chk("to_push2", push2, 10);
        chk("to_no_pop2", pop2, 0);
        chk("to_no_done", done_cnt, 0);
    endtask

    task automatic test_mid_filter_reset();
        bit seen;
        clear_mon();
        res_limit = NPIX;
        do_start();
        chk("mfr_err_cleared", err, 0);
        feed16();
        repeat (5) tick();
        chk("mfr_pop_cnt", pix_cnt, 5);
        #2 reset = 1'b1;
        #1;
        chk("mfr_outputs_zero", {in_ready, fifo1_en, fifo2_en, med_valid_in, out_valid,
                                 busy, done, err, pix_cnt}, 0);
        tick();
        reset = 1'b0;
        clear_mon();
        do_start();
        feed16();
        wait_done(seen);
        chk("mfr_done_seen", seen, 1);
        chk("mfr_push2", push2, NPIX);
        chk("mfr_pop2", pop2, NPIX);
        chk("mfr_out_valid", ov, NPIX);
        chk("mfr_done_cnt", done_cnt, 1);
        chk("mfr_viol", viol, 0);
    endtask

    task automatic test_ignored_events();
        clear_mon();
        res_limit = NPIX;
        do_start();
        start    = 1'b1;
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid  = 1'b0;
        med_force = 1'b1;
        #1;
        chk("ign_no_push2_load", fifo2_en, 0);
        tick();
        med_force = 1'b0;
        start     = 1'b0;
        chk("ign_load_cnt", pix_cnt, 4);
        chk("ign_still_load", {in_ready, busy}, 2'b11);
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        med_force = 1'b1;
        #1;
        chk("ign_no_push2_idle", fifo2_en, 0);
        repeat (2) tick();
        med_force = 1'b0;
        chk("ign_idle", {busy, pix_cnt}, 0);
        chk("ign_push2_total", push2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; med_force = 1'b0;
        res_limit = NPIX; mon_clr = 1'b1; cyc = 0;
        test_reset();
        test_normal_frame();
        test_gapped_input();
        test_timeout();
        test_mid_filter_reset();
        test_ignored_events();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/median_filter_ctrl.md
MEDIAN_FILTER_CTRL -- requirements
Module: median_filter_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the pixel-counter base width; counters SHALL be ADDR_WIDTH+1 bits.
REQ-002 Parameter ROW, default 256, SHALL set the image rows.
REQ-003 Parameter COL, default 256, SHALL set the image columns; N = ROW*COL pixels per frame.
REQ-004 Parameter TIMEOUT, default 1024, SHALL set the maximum number of idle cycles allowed in DRAIN before error.
REQ-005 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous active-high reset.
REQ-008 Port start, input, 1 bit: frame start request, sampled in IDLE only.
REQ-009 Port in_valid, input, 1 bit: a pixel is present on the datapath DATA_IN this cycle.
REQ-010 Port med_valid, input, 1 bit: the median stage is presenting a result this cycle.
REQ-011 Port in_ready, output, 1 bit: the controller accepts pixels (LOAD state).
REQ-012 Ports fifo1_en and fifo1_push_pop, outputs, 1 bit each: input FIFO operate strobe and direction (1 = push, 0 = pop).
REQ-013 Ports fifo2_en and fifo2_push_pop, outputs, 1 bit each: output FIFO operate strobe and direction (1 = push, 0 = pop).
REQ-014 Port med_valid_in, output, 1 bit: valid qualifier to the median stage.
REQ-015 Port out_valid, output, 1 bit: the output FIFO DATA_OUT holds a frame result.
REQ-016 Ports busy, done and err, outputs, 1 bit each: not IDLE; one-cycle completion pulse; DRAIN timeout flag.
REQ-017 Port pix_cnt, output, ADDR_WIDTH+1 bits: current-state counter value.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, FILTER, DRAIN, UNLOAD and DONE.
REQ-019 IDLE: all strobes SHALL be 0; start=1 SHALL go to LOAD and clear all counters and err.
REQ-020 LOAD: in_ready=1; each in_valid=1 SHALL drive fifo1_en=1 and fifo1_push_pop=1 combinationally that cycle and increment the load count; in_valid=0 SHALL produce no push.
REQ-021 LOAD SHALL go to FILTER on the cycle the Nth push occurs; in_ready SHALL be 0 from the next cycle.
REQ-022 FILTER: fifo1_en=1 and fifo1_push_pop=0 SHALL be driven on exactly N consecutive cycles, then the FSM SHALL go to DRAIN.
REQ-023 med_valid_in SHALL be a registered copy of the FILTER pop strobe, asserted one cycle after each pop (FIFO read latency 1).
REQ-024 In FILTER and DRAIN, each med_valid=1 SHALL drive fifo2_en=1 and fifo2_push_pop=1 that cycle and increment the result count.
REQ-025 The FSM SHALL go from FILTER or DRAIN to UNLOAD on the cycle the Nth result is pushed.
REQ-026 In DRAIN, an idle counter SHALL count consecutive med_valid=0 cycles; on reaching TIMEOUT the block SHALL set err=1 (held until next start) and go to IDLE without done.
REQ-027 UNLOAD: fifo2_en=1 and fifo2_push_pop=0 SHALL be driven on N consecutive cycles; out_valid SHALL be the pop strobe delayed one cycle.
REQ-028 After the Nth pop the FSM SHALL enter DONE, pulse done=1 for one cycle, then return to IDLE.
REQ-029 start outside IDLE and med_valid outside FILTER/DRAIN SHALL be ignored, with no counter change.
REQ-030 A FIFO SHALL never be pushed and popped in the same cycle; fifo2 pops SHALL start only after all N results are pushed.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, all counters to 0, and in_ready, fifo*_en, fifo*_push_pop, med_valid_in, out_valid, busy, done, err and pix_cnt to 0, including mid-frame; FIFO contents are cleared by the datapath's own reset.

Verification (ROW=COL=4, N=16, TIMEOUT=8; median model latency 3)
REQ-033 Reset: assert reset mid-cycle -> all outputs 0 without a clock edge; state IDLE.
REQ-034 Normal frame: start, then 16 contiguous in_valid -> 16 fifo1 pushes, 16 pops, 16 med_valid_in, 16 fifo2 pushes, 16 pops, 16 out_valid each one cycle after its pop, exactly one done pulse.
REQ-035 Gapped input: in_valid 1,0,1,0... -> pushes only on valid cycles; FILTER entered after the 16th push.
REQ-036 Timeout: med_valid stops after 10 results -> err=1 after 8 idle DRAIN cycles, IDLE, no done, no fifo2 pops.
REQ-037 Mid-FILTER reset: after 5 pops -> IDLE, all outputs 0; a following start and 16 pixels completes a normal frame.
REQ-038 Ignored events: start held during LOAD and med_valid pulsed in IDLE -> no state change, counts unchanged, no fifo2 push.
